// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer shared types: next-PC op encodings,
// sequencer states and default vectors.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ  = 2'd0,
    NPC_BR   = 2'd1,
    NPC_JAL  = 2'd2,
    NPC_JALR = 2'd3
  } npc_op_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } seq_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC_DEF  = 32'h0000_0100;
  localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/redirect_target_calc.sv
// Combinational redirect decision and target
// generation for EX-stage branches and jumps.
module redirect_target_calc
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] TRAP_PC = TRAP_PC_DEF
) (
  input  logic        i_ex_valid,
  input  logic [1:0]  i_ex_npc_op,
  input  logic        i_ex_branch_tag,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_rs1,
  input  logic [31:0] i_ex_imm,
  output logic        o_take,
  output logic [31:0] o_target,
  output logic        o_misalign
);

  logic [31:0] w_pc_rel;
  logic [31:0] w_reg_rel;
  logic [31:0] w_raw;
  logic        w_is_br;
  logic        w_is_jal;
  logic        w_is_jalr;

  assign w_is_br   = (i_ex_npc_op == NPC_BR);
  assign w_is_jal  = (i_ex_npc_op == NPC_JAL);
  assign w_is_jalr = (i_ex_npc_op == NPC_JALR);

  assign w_pc_rel  = i_ex_pc + i_ex_imm;
  assign w_reg_rel = (i_ex_rs1 + i_ex_imm) & ~32'h1;

  always_comb begin
    o_take = 1'b0;
    w_raw  = w_pc_rel;
    unique case (1'b1)
      w_is_jalr: begin
        o_take = i_ex_valid;
        w_raw  = w_reg_rel;
      end
      w_is_jal: o_take = i_ex_valid;
      w_is_br:  o_take = i_ex_valid & i_ex_branch_tag;
      default:  o_take = 1'b0;
    endcase
  end

  // bit 1 set means not word aligned; trap vector replaces it
  assign o_misalign = o_take & w_raw[1];
  assign o_target   = o_misalign ? TRAP_PC : w_raw;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: sequential stepping, stalls,
// EX redirects and buffered redirects over a held fetch.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] TRAP_PC  = TRAP_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_ready,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [1:0]  ex_npc_op,
  input  logic        ex_branch_tag,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_imm,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic        fetch_drop,
  output logic        misalign,
  output logic [31:0] redirect_cnt
);

  seq_state_e  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend;
  logic [31:0] r_cnt;
  logic        r_pc_valid;

  logic        w_take;
  logic [31:0] w_tgt;
  logic        w_mis;
  logic        w_live;

  redirect_target_calc #(
    .TRAP_PC(TRAP_PC)
  ) u_calc (
    .i_ex_valid     (ex_valid),
    .i_ex_npc_op    (ex_npc_op),
    .i_ex_branch_tag(ex_branch_tag),
    .i_ex_pc        (ex_pc),
    .i_ex_rs1       (ex_rs1),
    .i_ex_imm       (ex_imm),
    .o_take         (w_take),
    .o_target       (w_tgt),
    .o_misalign     (w_mis)
  );

  assign w_live = (r_state != ST_BOOT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_pend     <= '0;
      r_cnt      <= '0;
      r_pc_valid <= 1'b0;
    end else begin
      if (flush)
        r_cnt <= r_cnt + 32'd1;
      unique case (r_state)
        ST_BOOT: begin
          r_state    <= ST_RUN;
          r_pc_valid <= 1'b1;
        end
        ST_RUN: begin
          if (w_take && fetch_ready) begin
            r_pc <= w_tgt;
          end else if (w_take) begin
            r_pend  <= w_tgt;
            r_state <= ST_PEND;
          end else if (!stall && fetch_ready) begin
            r_pc <= r_pc + PC_STEP;
          end
        end
        ST_PEND: begin
          // newest redirect wins over the buffered one
          if (fetch_ready) begin
            r_pc    <= w_take ? w_tgt : r_pend;
            r_state <= ST_RUN;
          end else if (w_take) begin
            r_pend <= w_tgt;
          end
        end
        default: begin
          r_state    <= ST_BOOT;
          r_pc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pc           = r_pc;
  assign pc_valid     = r_pc_valid;
  assign flush        = w_live & w_take;
  assign misalign     = w_live & w_mis;
  assign fetch_drop   = (r_state == ST_PEND) & fetch_ready;
  assign redirect_cnt = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed plan
// followed by randomized traffic against a reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRP_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_ready = 1'b0;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic [1:0]  ex_npc_op = 2'd0;
  logic        ex_branch_tag = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_rs1 = '0;
  logic [31:0] ex_imm = '0;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        fetch_drop;
  logic        misalign;
  logic [31:0] redirect_cnt;

  pc_sequencer #(
    .RESET_PC(RST_PC),
    .TRAP_PC (TRP_PC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_ready  (fetch_ready),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_npc_op    (ex_npc_op),
    .ex_branch_tag(ex_branch_tag),
    .ex_pc        (ex_pc),
    .ex_rs1       (ex_rs1),
    .ex_imm       (ex_imm),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .flush        (flush),
    .fetch_drop   (fetch_drop),
    .misalign     (misalign),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        vld;
    logic        fl;
    logic        drop;
    logic        mis;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   done = 0;

  // reference model: fetch address, whether fetching has
  // started, and an optional buffered redirect destination
  logic [31:0] m_pc = RST_PC;
  bit          m_started = 0;
  bit          m_has_pend = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_cnt = '0;

  task automatic cyc(input bit rn, input bit fr, input bit st,
                     input bit ev, input logic [1:0] op,
                     input bit tg, input logic [31:0] epc,
                     input logic [31:0] rs1,
                     input logic [31:0] imm, input string nm);
    exp_t        e;
    bit          take;
    logic [31:0] dest;
    @(negedge clk);
    #1;
    rst_n = rn; fetch_ready = fr; stall = st;
    ex_valid = ev; ex_npc_op = op; ex_branch_tag = tg;
    ex_pc = epc; ex_rs1 = rs1; ex_imm = imm;
    e.tag = nm;
    take = ev && (op == 2 || op == 3 || (op == 1 && tg));
    if (op == 3) dest = (rs1 + imm) & ~32'h1;
    else dest = epc + imm;
    if (!rn) begin
      m_pc = RST_PC; m_started = 0; m_has_pend = 0; m_cnt = 0;
      e.pc = RST_PC; e.vld = 0; e.fl = 0;
      e.drop = 0; e.mis = 0; e.cnt = 0;
    end else if (!m_started) begin
      e.pc = m_pc; e.vld = 0; e.fl = 0;
      e.drop = 0; e.mis = 0; e.cnt = m_cnt;
      m_started = 1;
    end else begin
      e.pc = m_pc; e.vld = 1; e.fl = take;
      e.mis = take && dest[1];
      e.drop = m_has_pend && fr;
      e.cnt = m_cnt;
      if (e.mis) dest = TRP_PC;
      if (take) m_cnt = m_cnt + 1;
      if (take && fr) begin
        m_pc = dest; m_has_pend = 0;
      end else if (take) begin
        m_pend = dest; m_has_pend = 1;
      end else if (m_has_pend && fr) begin
        m_pc = m_pend; m_has_pend = 0;
      end else if (!m_has_pend && !st && fr) begin
        m_pc = m_pc + 4;
      end
    end
    q.push_back(e);
  endtask

  task automatic idle(input bit fr, input bit st, input string nm);
    cyc(1, fr, st, 0, 2'd0, 0, '0, '0, '0, nm);
  endtask

  task automatic chk32(input string nm, input logic [31:0] a,
                       input logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, a, x);
    end
  endtask

  // monitor: every cycle the DUT presents outputs after the
  // driver settles; pop the oldest expectation and compare
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk32({e.tag, ".pc"}, pc, e.pc);
        chk32({e.tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, e.vld});
        chk32({e.tag, ".flush"}, {31'd0, flush}, {31'd0, e.fl});
        chk32({e.tag, ".fetch_drop"}, {31'd0, fetch_drop},
              {31'd0, e.drop});
        chk32({e.tag, ".misalign"}, {31'd0, misalign}, {31'd0, e.mis});
        chk32({e.tag, ".cnt"}, redirect_cnt, e.cnt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    cyc(0, 1, 0, 0, 2'd0, 0, '0, '0, '0, "reset");
    cyc(0, 1, 0, 0, 2'd0, 0, '0, '0, '0, "reset");
    idle(1, 0, "boot");
    idle(1, 0, "run0");
    idle(1, 0, "run4");
    idle(1, 0, "run8");
    idle(1, 1, "stall1");
    idle(1, 1, "stall2");
    idle(1, 0, "unstall");
    idle(1, 0, "seqC");
    cyc(1, 1, 0, 1, 2'd1, 1, 32'h10, '0, 32'h20, "br_take");
    cyc(1, 1, 0, 1, 2'd1, 0, 32'h10, '0, 32'h20, "br_not");
    cyc(1, 1, 1, 1, 2'd1, 1, 32'h10, '0, 32'h20, "br_stall");
    idle(1, 0, "at30");
    cyc(1, 1, 0, 1, 2'd3, 0, '0, 32'h1001, 32'h4, "jalr_ok");
    idle(1, 0, "at1004");
    cyc(1, 1, 0, 1, 2'd3, 0, '0, 32'h1002, 32'h0, "jalr_mis");
    idle(1, 0, "at100");
    cyc(1, 1, 0, 1, 2'd2, 0, 32'h20, '0, 32'h20, "to40");
    cyc(1, 0, 0, 1, 2'd2, 0, 32'h20, '0, 32'h80, "pend_jal");
    idle(0, 0, "pend_h1");
    idle(0, 1, "pend_h2");
    idle(1, 0, "pend_drop");
    idle(1, 0, "atA0");
    cyc(1, 0, 0, 1, 2'd2, 0, 32'h20, '0, 32'h80, "pend2");
    cyc(1, 0, 0, 1, 2'd3, 0, '0, 32'h2002, 32'h0, "pend2_mis");
    cyc(0, 1, 0, 0, 2'd0, 0, '0, '0, '0, "pend_rst");
    idle(1, 1, "boot2");
    idle(1, 1, "run_st");
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] imm;
      logic [31:0] r;
      r = $urandom;
      imm = $urandom;
      if (r[3:2] != 0) imm[1:0] = 2'b00;
      cyc(r[31:25] != 0, r[9:8] != 0, r[10] & r[11],
          r[14:12] < 3, r[16:15], r[17],
          $urandom, $urandom, imm, "rand");
    end
    idle(1, 0, "tail");
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    #5;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the fetch PC register and sequences it around next-PC selection, hazard stalls and EX-stage redirects (branch/JAL/JALR). Sits between the EX stage and the instruction-memory fetch port. Issues the pipeline flush on taken redirects. Buffers a redirect that arrives while a fetch handshake is outstanding, then marks the stale fetch for discard.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset.
TRAP_PC, 32'h0000_0100, target used when a redirect target is misaligned.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
fetch_ready  in  1  imem accepts pc this cycle.
stall  in  1  hazard unit hold request.
ex_valid  in  1  EX stage holds a valid instruction.
ex_npc_op  in  2  0 sequential, 1 conditional branch, 2 JAL, 3 JALR.
ex_branch_tag  in  1  branch condition result.
ex_pc  in  32  PC of the EX instruction.
ex_rs1  in  32  rs1 operand for JALR.
ex_imm  in  32  immediate offset.
pc  out  32  current fetch address.
pc_valid  out  1  fetch request valid.
flush  out  1  kill IF/ID and ID/EX contents.
fetch_drop  out  1  fetch accepted this cycle must be discarded.
misalign  out  1  redirect target misaligned; TRAP_PC substituted.
redirect_cnt  out  32  count of taken redirects.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: pc=RESET_PC, pc_valid=0, flush=0, fetch_drop=0, misalign=0, redirect_cnt=0, state=BOOT. Any pending target is discarded.
- Redirect taken (combinational), take = ex_valid && (op==2 || op==3 || (op==1 && ex_branch_tag)). op==0 never redirects.
- Target for op 1/2 = ex_pc+ex_imm. Target for op 3 = (ex_rs1+ex_imm) & ~32'h1.
- All adds are 32-bit and wrap modulo 2^32.
- Misalign: when take && target[1]==1, misalign=1 in the same cycle and TRAP_PC replaces the target.
- flush = take, combinational, in RUN or PEND. Never asserted in BOOT.
- redirect_cnt increments on every clock where flush=1, misaligned cases included. It wraps at 2^32.
- Handshake rule: a fetch is accepted when pc_valid && fetch_ready. While pc_valid=1 && fetch_ready=0, pc must not change.
- State BOOT: pc_valid=0. Goes to RUN on the next edge; pc stays RESET_PC.
- State RUN: pc_valid=1. Priority order, highest first:
  - take && fetch_ready: pc<=target; stay RUN.
  - take && !fetch_ready: pend_target<=target; go to PEND; pc held.
  - !stall && fetch_ready: pc<=pc+4.
  - otherwise: hold.
- Redirect beats stall.
- State PEND: pc_valid=1; pc held at the old value; stall ignored.
  - A new take overwrites pend_target and raises flush and misalign again.
  - When fetch_ready=1: fetch_drop=1 (combinational), pc<=pend_target (or the new target if take in the same cycle), go to RUN.
- fetch_drop is 0 in every other case.
- Reset asserted mid-PEND: immediate return to BOOT with reset values.

Decomposition:
- Shared package/header: npc_op encodings NPC_SEQ=0, NPC_BR=1, NPC_JAL=2, NPC_JALR=3; state encoding BOOT/RUN/PEND (2-bit); TRAP_PC default.
- One sub-module, redirect_target_calc: purely combinational, producing take, the target (JALR LSB cleared, TRAP_PC substituted) and misalign.
- pc_sequencer holds the FSM, pc, pend_target and the counter.

Test Plan:
- Reset release with fetch_ready=1, stall=0:
  - first edge: pc=0x0, pc_valid=0.
  - next: pc=0x0, pc_valid=1.
  - then pc=0x4, 0x8, 0xC; flush never asserted.
- stall=1 for 2 cycles at pc=0x8 -> pc stays 0x8 both cycles, then 0xC; redirect_cnt=0.
- Branch taken: op=1, tag=1, ex_pc=0x10, ex_imm=0x20, fetch_ready=1 -> flush=1 that cycle, next pc=0x30, redirect_cnt=1.
- Branch not taken: tag=0 -> flush=0, pc+4. Taken branch with stall=1 -> still redirects to 0x30.
- JALR: rs1=0x1001, imm=0x4 -> next pc=0x1004, misalign=0. JALR rs1=0x1002, imm=0 -> misalign=1, flush=1, next pc=0x100.
- Pending redirect, with fetch_ready=0 and pc=0x40:
  - JAL ex_pc=0x20, imm=0x80 -> flush=1, pc held at 0x40 for 3 cycles.
  - fetch_ready=1 -> fetch_drop=1, next pc=0xA0.
  - Second variant: assert rst_n=0 during PEND -> pc=RESET_PC, pc_valid=0, fetch_drop=0 immediately.
